// File: rtl/pe_ns_pkg.sv
// rtl/pe_ns_pkg.sv - shared widths, depth and pointer-width helper for the N/S pass-through PE
package pe_ns_pkg;

  localparam int NS_DATA_WIDTH = 130;
  localparam int NS_FIFO_DEPTH = 2;
  localparam int NS_CNT_WIDTH  = 32;

  // Smallest w with 2**w >= depth, never below 1 so pointers always exist.
  function automatic int ptr_width(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pe_ns_fifo.sv
// rtl/pe_ns_fifo.sv - register-array FIFO with push/pop/full/empty/head, sync active-low reset
module pe_ns_fifo
  import pe_ns_pkg::*;
#(
  parameter int WIDTH = NS_DATA_WIDTH,
  parameter int DEPTH = NS_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // Contents are cleared too so the head reads zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/pe_empty_ns_link.sv
// rtl/pe_empty_ns_link.sv - N/S pass-through link PE; optional pop counters via PE_NS_WORD_CNT_EN
module pe_empty_ns_link
  import pe_ns_pkg::*;
#(
  parameter int NORTH_WIDTH = NS_DATA_WIDTH,
  parameter int SOUTH_WIDTH = NS_DATA_WIDTH,
  parameter int FIFO_DEPTH  = NS_FIFO_DEPTH,
  parameter int CNT_WIDTH   = NS_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ap_start,
  input  logic [SOUTH_WIDTH-1:0] in_from_north,
  input  logic                   in_from_north_valid,
  output logic                   in_from_north_ready,
  output logic [SOUTH_WIDTH-1:0] out_to_south,
  output logic                   out_to_south_valid,
  input  logic                   out_to_south_ready,
  input  logic [NORTH_WIDTH-1:0] in_from_south,
  input  logic                   in_from_south_valid,
  output logic                   in_from_south_ready,
  output logic [NORTH_WIDTH-1:0] out_to_north,
  output logic                   out_to_north_valid,
  input  logic                   out_to_north_ready
`ifdef PE_NS_WORD_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]   north_cnt,
  output logic [CNT_WIDTH-1:0]   south_cnt
`endif
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt
    $error("CNT_WIDTH must be at least 1");
  end

  // Reset also masks the handshakes so nothing is offered while it is held.
  logic run;
  assign run = ap_start & reset;

  logic s_full, s_empty, s_push, s_pop;
  logic n_full, n_empty, n_push, n_pop;

  assign in_from_north_ready = run & ~s_full;
  assign out_to_south_valid  = run & ~s_empty;
  assign s_push = in_from_north_valid & in_from_north_ready;
  assign s_pop  = out_to_south_valid & out_to_south_ready;

  assign in_from_south_ready = run & ~n_full;
  assign out_to_north_valid  = run & ~n_empty;
  assign n_push = in_from_south_valid & in_from_south_ready;
  assign n_pop  = out_to_north_valid & out_to_north_ready;

  pe_ns_fifo #(
    .WIDTH (SOUTH_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_south_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s_push),
    .push_data (in_from_north),
    .pop       (s_pop),
    .head      (out_to_south),
    .full      (s_full),
    .empty     (s_empty)
  );

  pe_ns_fifo #(
    .WIDTH (NORTH_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_north_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (n_push),
    .push_data (in_from_south),
    .pop       (n_pop),
    .head      (out_to_north),
    .full      (n_full),
    .empty     (n_empty)
  );

`ifdef PE_NS_WORD_CNT_EN
  // Pops cannot happen with ap_start low, so the counters hold then for free.
  always_ff @(posedge clk) begin
    if (!reset) begin
      north_cnt <= '0;
      south_cnt <= '0;
    end else begin
      if (n_pop) north_cnt <= north_cnt + 1'b1;
      if (s_pop) south_cnt <= south_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_empty_ns_link.sv
// tb/tb_pe_empty_ns_link.sv - self-checking bench: vector table, corner sequences, random traffic vs queue model
module tb_pe_empty_ns_link;

  localparam int W = 130;
  localparam int D = 2;
`ifdef PE_NS_WORD_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 32;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ap_start = 1'b0;
  logic [W-1:0] in_from_north = '0;
  logic         in_from_north_valid = 1'b0;
  logic         in_from_north_ready;
  logic [W-1:0] out_to_south;
  logic         out_to_south_valid;
  logic         out_to_south_ready = 1'b0;
  logic [W-1:0] in_from_south = '0;
  logic         in_from_south_valid = 1'b0;
  logic         in_from_south_ready;
  logic [W-1:0] out_to_north;
  logic         out_to_north_valid;
  logic         out_to_north_ready = 1'b0;
`ifdef PE_NS_WORD_CNT_EN
  logic [CW-1:0] north_cnt;
  logic [CW-1:0] south_cnt;
`endif

  always #5 clk = ~clk;

  pe_empty_ns_link #(
    .NORTH_WIDTH (W),
    .SOUTH_WIDTH (W),
    .FIFO_DEPTH  (D),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .ap_start            (ap_start),
    .in_from_north       (in_from_north),
    .in_from_north_valid (in_from_north_valid),
    .in_from_north_ready (in_from_north_ready),
    .out_to_south        (out_to_south),
    .out_to_south_valid  (out_to_south_valid),
    .out_to_south_ready  (out_to_south_ready),
    .in_from_south       (in_from_south),
    .in_from_south_valid (in_from_south_valid),
    .in_from_south_ready (in_from_south_ready),
    .out_to_north        (out_to_north),
    .out_to_north_valid  (out_to_north_valid),
    .out_to_north_ready  (out_to_north_ready)
`ifdef PE_NS_WORD_CNT_EN
    ,
    .north_cnt           (north_cnt),
    .south_cnt           (south_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: one bounded queue per direction plus pop counts.
  logic [W-1:0]  q_ns[$];
  logic [W-1:0]  q_sn[$];
  logic [W-1:0]  log_south[$];
  logic [W-1:0]  log_north[$];
  logic [CW-1:0] m_south_cnt = '0;
  logic [CW-1:0] m_north_cnt = '0;
  bit            pushed_ns;
  bit            pushed_sn;

  typedef struct {
    logic         rst;
    logic         ap;
    logic         nv;
    logic [W-1:0] nd;
    logic         sr;
    logic         e_nr;
    logic         e_sv;
    logic         chk_d;
    logic [W-1:0] e_sd;
  } row_t;

  row_t tbl[5];

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare outputs against the model, then take one edge and advance the model.
  task automatic model_step();
    bit run, e_nr, e_sv, e_sr, e_nv;
    run  = (ap_start === 1'b1) && (reset === 1'b1);
    e_nr = run && (q_ns.size() < D);
    e_sv = run && (q_ns.size() > 0);
    e_sr = run && (q_sn.size() < D);
    e_nv = run && (q_sn.size() > 0);
    check1("in_from_north_ready", in_from_north_ready, e_nr);
    check1("out_to_south_valid", out_to_south_valid, e_sv);
    check1("in_from_south_ready", in_from_south_ready, e_sr);
    check1("out_to_north_valid", out_to_north_valid, e_nv);
    if (e_sv) checkw("out_to_south_data", out_to_south, q_ns[0]);
    if (e_nv) checkw("out_to_north_data", out_to_north, q_sn[0]);
`ifdef PE_NS_WORD_CNT_EN
    checki("south_cnt", int'(south_cnt), int'(m_south_cnt));
    checki("north_cnt", int'(north_cnt), int'(m_north_cnt));
`endif
    if (e_sv && out_to_south_ready) log_south.push_back(out_to_south);
    if (e_nv && out_to_north_ready) log_north.push_back(out_to_north);
    @(posedge clk);
    pushed_ns = 1'b0;
    pushed_sn = 1'b0;
    if (!reset) begin
      q_ns.delete();
      q_sn.delete();
      m_south_cnt = '0;
      m_north_cnt = '0;
    end else begin
      if (e_sv && out_to_south_ready) begin
        void'(q_ns.pop_front());
        m_south_cnt = m_south_cnt + 1'b1;
      end
      if (e_nv && out_to_north_ready) begin
        void'(q_sn.pop_front());
        m_north_cnt = m_north_cnt + 1'b1;
      end
      if (e_nr && in_from_north_valid) begin
        q_ns.push_back(in_from_north);
        pushed_ns = 1'b1;
      end
      if (e_sr && in_from_south_valid) begin
        q_sn.push_back(in_from_south);
        pushed_sn = 1'b1;
      end
    end
    #1;
  endtask

  task automatic cycle();
    #1;
    model_step();
  endtask

  task automatic idle_inputs();
    in_from_north_valid = 1'b0;
    in_from_south_valid = 1'b0;
    in_from_north       = '0;
    in_from_south       = '0;
  endtask

  initial begin
    logic [W-1:0] words[3];
    int idx;
    int pushes;

    tbl[0] = '{1'b0, 1'b1, 1'b1, W'(1), 1'b1, 1'b0, 1'b0, 1'b1, W'(0)};
    tbl[1] = '{1'b1, 1'b1, 1'b1, W'(1), 1'b1, 1'b1, 1'b0, 1'b0, W'(0)};
    tbl[2] = '{1'b1, 1'b1, 1'b1, W'(2), 1'b1, 1'b1, 1'b1, 1'b1, W'(1)};
    tbl[3] = '{1'b1, 1'b1, 1'b0, W'(0), 1'b1, 1'b1, 1'b1, 1'b1, W'(2)};
    tbl[4] = '{1'b1, 1'b1, 1'b0, W'(0), 1'b1, 1'b1, 1'b0, 1'b0, W'(0)};

    @(posedge clk);
    @(posedge clk);
    #1;
    model_step();

    // Vector table: first-word latency north->south.
    out_to_north_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      reset               = tbl[r].rst;
      ap_start            = tbl[r].ap;
      in_from_north_valid = tbl[r].nv;
      in_from_north       = tbl[r].nd;
      out_to_south_ready  = tbl[r].sr;
      #1;
      check1("tbl_north_ready", in_from_north_ready, tbl[r].e_nr);
      check1("tbl_south_valid", out_to_south_valid, tbl[r].e_sv);
      check1("tbl_north_ready_rst", in_from_south_ready, tbl[r].rst);
      if (tbl[r].chk_d) checkw("tbl_south_data", out_to_south, tbl[r].e_sd);
      model_step();
    end

    // Backpressure from north: two words fill the FIFO, third waits.
    words[0] = W'(32'hA);
    words[1] = W'(32'hB);
    words[2] = W'(32'hC);
    idx = 0;
    log_north.delete();
    out_to_north_ready = 1'b0;
    for (int k = 0; k < 12 && (idx < 3 || q_sn.size() > 0); k++) begin
      in_from_south_valid = (idx < 3);
      in_from_south       = (idx < 3) ? words[idx] : '0;
      if (k >= 4) out_to_north_ready = 1'b1;
      cycle();
      if (pushed_sn) idx++;
      if (k == 2) check1("south_ready_when_full", in_from_south_ready, 1'b0);
    end
    idle_inputs();
    checki("backpressure_accepted", idx, 3);
    checki("backpressure_out_count", log_north.size(), 3);
    for (int i = 0; i < 3 && i < log_north.size(); i++) checkw("backpressure_order", log_north[i], words[i]);

    // Steady stream, both directions, 100 words each.
    log_north.delete();
    log_south.delete();
    out_to_north_ready = 1'b1;
    out_to_south_ready = 1'b1;
    pushes = 0;
    for (int k = 0; k < 100; k++) begin
      in_from_north_valid = 1'b1;
      in_from_north       = W'(32'h1000 + k);
      in_from_south_valid = 1'b1;
      in_from_south       = W'(32'h2000 + k);
      cycle();
      if (pushed_ns && pushed_sn) pushes++;
    end
    idle_inputs();
    cycle();
    cycle();
    checki("stream_one_per_cycle", pushes, 100);
    checki("stream_south_count", log_south.size(), 100);
    checki("stream_north_count", log_north.size(), 100);
    for (int i = 0; i < 100 && i < log_south.size() && i < log_north.size(); i++) begin
      checkw("stream_south_order", log_south[i], W'(32'h1000 + i));
      checkw("stream_north_order", log_north[i], W'(32'h2000 + i));
    end

    // ap_start low with one buffered word: frozen, then same word resumes.
    out_to_south_ready  = 1'b0;
    in_from_north_valid = 1'b1;
    in_from_north       = {2'b10, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210};
    cycle();
    idle_inputs();
    ap_start = 1'b0;
    out_to_south_ready = 1'b1;
    in_from_north_valid = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    in_from_north_valid = 1'b0;
    ap_start = 1'b1;
    log_south.delete();
    cycle();
    cycle();
    checki("resume_count", log_south.size(), 1);
    if (log_south.size() > 0)
      checkw("resume_word", log_south[0], {2'b10, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210});

    // Reset while full discards contents.
    out_to_south_ready = 1'b0;
    in_from_north_valid = 1'b1;
    in_from_north = W'(32'h77);
    cycle();
    in_from_north = W'(32'h88);
    cycle();
    check1("full_before_reset", in_from_north_ready, 1'b0);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    in_from_north_valid = 1'b0;
    #1;
    check1("post_reset_valid", out_to_south_valid, 1'b0);
    checkw("post_reset_data", out_to_south, '0);
    model_step();
    log_south.delete();
    out_to_south_ready  = 1'b1;
    in_from_north_valid = 1'b1;
    in_from_north       = W'(32'h55);
    cycle();
    idle_inputs();
    cycle();
    cycle();
    checki("post_reset_count", log_south.size(), 1);
    if (log_south.size() > 0) checkw("post_reset_word", log_south[0], W'(32'h55));

`ifdef PE_NS_WORD_CNT_EN
    // Counter wrap: 17 pops on a 4-bit counter.
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    out_to_north_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      in_from_south_valid = 1'b1;
      in_from_south       = W'(k);
      cycle();
    end
    idle_inputs();
    cycle();
    cycle();
    checki("north_cnt_wrap", int'(north_cnt), 1);
`endif

    // Randomised traffic against the queue model.
    for (int k = 0; k < 1500; k++) begin
      reset               = ($urandom_range(99) != 0);
      ap_start            = ($urandom_range(9) != 0);
      in_from_north_valid = $urandom_range(1) == 1;
      in_from_south_valid = $urandom_range(1) == 1;
      out_to_south_ready  = $urandom_range(3) != 0;
      out_to_north_ready  = $urandom_range(3) != 0;
      in_from_north = W'({$urandom, $urandom, $urandom, $urandom, $urandom});
      in_from_south = W'({$urandom, $urandom, $urandom, $urandom, $urandom});
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
